mem_fill_controller: RTL and testbench
======================================

MEM_FILL_CONTROLLER -- requirements
Module: mem_fill_controller

Interface
REQ-001 SHALL have parameter RAM_LATENCY, default 2, cycles per RAM access (legal 1..15).
REQ-002 SHALL have port clock  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  cache miss request present.
REQ-005 SHALL have port req_ready  output  1  controller can accept a request.
REQ-006 SHALL have port req_address  input  8  address of missed word.
REQ-007 SHALL have port wb_valid  input  1  victim line is valid and dirty; write-back required.
REQ-008 SHALL have port wb_address  input  8  victim tag (RAM address).
REQ-009 SHALL have port wb_data  input  8  victim data.
REQ-010 SHALL have port fill_valid  output  1  one-cycle strobe, fill data valid.
REQ-011 SHALL have port fill_address  output  8  address being filled.
REQ-012 SHALL have port fill_data  output  8  RAM word for fill_address.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL hold a 256 x 8 RAM; word a initialised to value a (mem[0x04]=0x04 etc.).
REQ-015 SHALL implement FSM states IDLE, WB, RD, FILL.
REQ-016 SHALL assert req_ready only in IDLE; request accepted on a cycle with req_valid=1 and req_ready=1.
REQ-017 On acceptance SHALL register req_address, wb_valid, wb_address and wb_data; later changes on these inputs SHALL be ignored.
REQ-018 Transition on acceptance: to WB if captured wb_valid=1, else to RD.
REQ-019 SHALL remain in WB exactly RAM_LATENCY cycles, write wb_data to mem[wb_address] on the last WB cycle, then enter RD.
REQ-020 SHALL remain in RD exactly RAM_LATENCY cycles, read mem[req_address] on the last RD cycle, then enter FILL.
REQ-021 In FILL SHALL drive fill_valid=1, fill_address=captured req_address, fill_data=read word, for exactly one cycle, then return to IDLE.
REQ-022 Latency: request accepted at edge T -> fill_valid high in cycle T+RAM_LATENCY+1 (clean victim), T+2*RAM_LATENCY+1 (dirty victim).
REQ-023 When wb_address equals req_address, fill_data SHALL be the just-written wb_data.
REQ-024 A wait-state counter of 4 bits SHALL load RAM_LATENCY-1 on state entry and count down to 0; no wrap-around is permitted.
REQ-025 Back-to-back requests: req_ready SHALL rise the cycle after FILL; minimum spacing between accepted requests is RAM_LATENCY+2 cycles.
REQ-026 fill_address and fill_data SHALL hold their last values while fill_valid=0.
REQ-027 req_valid while busy SHALL have no effect; the requester holds it until accepted.

Reset
REQ-028 With resetn=0 at a rising edge: state=IDLE, counter=0, fill_valid=0, fill_address=0x00, fill_data=0x00, busy=0, req_ready=1 after that edge.
REQ-029 Reset mid-operation (WB or RD) SHALL abort the transaction without issuing fill_valid; a write-back not yet reaching its last WB cycle SHALL NOT modify RAM.
REQ-030 RAM contents SHALL NOT be altered by reset.

Structure
REQ-031 Shared package SHALL hold the FSM state encoding (2 bits), ADDR_W=8, DATA_W=8 and the RAM depth 256.
REQ-032 The RAM array SHALL be a separate sub-module ram_256x8 (synchronous write, one read port); FSM and counter stay in mem_fill_controller.

Verification
REQ-033 Clean miss: RAM_LATENCY=2, req_address=0x10, wb_valid=0 accepted at T -> fill_valid only at T+3, fill_data=0x10.
REQ-034 Dirty miss: req_address=0x20, wb_valid=1, wb_address=0x04, wb_data=0xAA -> fill at T+5 with 0x20; later read of 0x04 returns 0xAA.
REQ-035 Same-address: req_address=wb_address=0x33, wb_data=0x5C, wb_valid=1 -> fill_data=0x5C.
REQ-036 Busy rejection: req_valid held during transaction with different address 0x40 -> req_ready=0 throughout, 0x40 accepted the cycle after FILL.
REQ-037 Reset in WB: assert resetn=0 on first WB cycle -> no fill_valid, mem[wb_address] unchanged, req_ready=1 after the reset edge.
REQ-038 RAM_LATENCY=1: clean miss accepted at T -> fill at T+2; dirty miss -> fill at T+3.

Source files
------------

// File: rtl/mem_fill_controller_pkg.sv
// Shared definitions for the cache-line fill controller: widths, RAM geometry,
// FSM encoding and the power-up RAM image.
package mem_fill_controller_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 8;
  localparam int RAM_DEPTH = 256;
  localparam int CNT_W     = 4;
  localparam int MEM_W     = RAM_DEPTH * DATA_W;
  localparam int BYTE_SH   = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RD   = 2'd2,
    FILL = 2'd3
  } state_t;

  // Power-up contents: word a holds value a. Built by shifting bytes in from
  // the top so word 0 lands in the least significant byte.
  function automatic logic [MEM_W-1:0] ram_identity_image();
    logic [MEM_W-1:0] img;
    img = '0;
    for (int i = RAM_DEPTH - 1; i >= 0; i--) begin
      img = {img[MEM_W-DATA_W-1:0], DATA_W'(i)};
    end
    return img;
  endfunction

endpackage

// File: rtl/mem_fill_controller_ram_256x8.sv
// 256 x 8 RAM: synchronous write, one asynchronous read port. Contents come up
// as the identity image and are never touched by reset.
module ram_256x8
  import mem_fill_controller_pkg::*;
(
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = ADDR_W + BYTE_SH;

  logic [MEM_W-1:0] mem_q = ram_identity_image();
  logic [MEM_W-1:0] mem_d;
  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx;

  assign widx = {waddr, {BYTE_SH{1'b0}}};
  assign ridx = {raddr, {BYTE_SH{1'b0}}};

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[widx +: DATA_W] = wdata;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign rdata = mem_q[ridx +: DATA_W];

endmodule

// File: rtl/mem_fill_controller.sv
// Cache miss fill controller: optional victim write-back, then a RAM read,
// then a one-cycle fill strobe. Each RAM access takes RAM_LATENCY cycles.
module mem_fill_controller
  import mem_fill_controller_pkg::*;
#(
  parameter int RAM_LATENCY = 2
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_address,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [DATA_W-1:0] wb_data,
  output logic              fill_valid,
  output logic [ADDR_W-1:0] fill_address,
  output logic [DATA_W-1:0] fill_data,
  output logic              busy,
  output state_t            dbg_state
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(RAM_LATENCY - 1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic                wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                fill_valid_q, fill_valid_d;
  logic [ADDR_W-1:0]   fill_addr_q, fill_addr_d;
  logic [DATA_W-1:0]   fill_data_q, fill_data_d;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_rdata;

  // Handshake: a request transfers on a rising edge where req_valid and
  // req_ready are both 1; the requester holds req_valid and its payload until then.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_addr_d   = req_addr_q;
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    ram_we       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          req_addr_d = req_address;
          wb_valid_d = wb_valid;
          wb_addr_d  = wb_address;
          wb_data_d  = wb_data;
          state_d    = wb_valid ? WB : RD;
          cnt_d      = WAIT_LOAD;
        end
      end
      WB: begin
        if (cnt_q == '0) begin
          // Gated by resetn so an aborting reset edge never commits the write.
          ram_we  = resetn && wb_valid_q;
          state_d = RD;
          cnt_d   = WAIT_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RD: begin
        if (cnt_q == '0) begin
          state_d      = FILL;
          fill_valid_d = 1'b1;
          fill_addr_d  = req_addr_q;
          fill_data_d  = ram_rdata;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      FILL: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_addr_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_addr_q   <= req_addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
    end
  end

  ram_256x8 u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wb_addr_q),
    .wdata (wb_data_q),
    .raddr (req_addr_q),
    .rdata (ram_rdata)
  );

  assign req_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign fill_valid   = fill_valid_q;
  assign fill_address = fill_addr_q;
  assign fill_data    = fill_data_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_fill_controller.sv
// Bench for mem_fill_controller: two instances (RAM_LATENCY 2 and 1) driven in
// turn with directed and random misses, checked against a word-array RAM model.
module tb_mem_fill_controller;
  import mem_fill_controller_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       resetn       [2];
  logic       req_valid    [2];
  logic       req_ready    [2];
  logic [7:0] req_address  [2];
  logic       wb_valid     [2];
  logic [7:0] wb_address   [2];
  logic [7:0] wb_data      [2];
  logic       fill_valid   [2];
  logic [7:0] fill_address [2];
  logic [7:0] fill_data    [2];
  logic       busy         [2];
  state_t     dbg_state    [2];

  mem_fill_controller #(.RAM_LATENCY(2)) u_dut0 (
    .clock(clock), .resetn(resetn[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_address(req_address[0]), .wb_valid(wb_valid[0]), .wb_address(wb_address[0]),
    .wb_data(wb_data[0]), .fill_valid(fill_valid[0]), .fill_address(fill_address[0]),
    .fill_data(fill_data[0]), .busy(busy[0]), .dbg_state(dbg_state[0])
  );

  mem_fill_controller #(.RAM_LATENCY(1)) u_dut1 (
    .clock(clock), .resetn(resetn[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_address(req_address[1]), .wb_valid(wb_valid[1]), .wb_address(wb_address[1]),
    .wb_data(wb_data[1]), .fill_valid(fill_valid[1]), .fill_address(fill_address[1]),
    .fill_data(fill_data[1]), .busy(busy[1]), .dbg_state(dbg_state[1])
  );

  // ---------------- reference model ----------------
  int         lat [2] = '{2, 1};
  logic [7:0] ref_mem [2][256];
  logic [7:0] last_fa [2];
  logic [7:0] last_fd [2];
  int         n_vec = 0;
  int         n_err = 0;

  function automatic string tg(input int d, input string s);
    return $sformatf("u%0d_%s", d, s);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Entered and left at a negedge with the DUT idle. Fill is expected in the
  // cycle ending at edge T+L+1 (clean) or T+2L+1 (dirty), i.e. sampled at the
  // negedge following edge T+L or T+2L.
  task automatic do_txn(input int d, input logic [7:0] a, input logic wv,
                        input logic [7:0] wa, input logic [7:0] wd,
                        input bit hold, input logic [7:0] next_a, output int waited);
    int         exp_j;
    logic [7:0] exp_fd;
    req_valid[d]   = 1'b1;
    req_address[d] = a;
    wb_valid[d]    = wv;
    wb_address[d]  = wa;
    wb_data[d]     = wd;
    waited = 0;
    while (req_ready[d] !== 1'b1 && waited < 64) begin
      @(negedge clock);
      waited++;
    end
    check_eq(tg(d, "ready_wait"), 32'(waited < 64), 32'd1);
    if (waited >= 64) begin
      req_valid[d] = 1'b0;
      return;
    end
    if (wv) ref_mem[d][wa] = wd;
    exp_fd = ref_mem[d][a];
    exp_j  = wv ? 2 * lat[d] : lat[d];
    @(posedge clock);
    @(negedge clock);
    if (hold) begin
      req_address[d] = next_a;
      wb_valid[d]    = 1'b0;
    end else begin
      req_valid[d]   = 1'b0;
      req_address[d] = 8'($urandom);
      wb_valid[d]    = 1'($urandom);
      wb_address[d]  = 8'($urandom);
      wb_data[d]     = 8'($urandom);
    end
    for (int j = 0; j <= exp_j; j++) begin
      if (j > 0) @(negedge clock);
      check_eq(tg(d, "busy_in_txn"), 32'(busy[d]), 32'd1);
      check_eq(tg(d, "ready_in_txn"), 32'(req_ready[d]), 32'd0);
      if (j == exp_j) begin
        check_eq(tg(d, "fill_valid_on"), 32'(fill_valid[d]), 32'd1);
        check_eq(tg(d, "fill_address"), 32'(fill_address[d]), 32'(a));
        check_eq(tg(d, "fill_data"), 32'(fill_data[d]), 32'(exp_fd));
      end else begin
        check_eq(tg(d, "fill_valid_early"), 32'(fill_valid[d]), 32'd0);
        check_eq(tg(d, "fill_addr_hold"), 32'(fill_address[d]), 32'(last_fa[d]));
      end
    end
    @(negedge clock);
    check_eq(tg(d, "fill_valid_off"), 32'(fill_valid[d]), 32'd0);
    check_eq(tg(d, "ready_after_fill"), 32'(req_ready[d]), 32'd1);
    check_eq(tg(d, "busy_after_fill"), 32'(busy[d]), 32'd0);
    check_eq(tg(d, "fill_data_hold"), 32'(fill_data[d]), 32'(exp_fd));
    last_fa[d] = a;
    last_fd[d] = exp_fd;
  endtask

  task automatic idle_cycles(input int d, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_eq(tg(d, "idle_fill_valid"), 32'(fill_valid[d]), 32'd0);
      check_eq(tg(d, "idle_ready"), 32'(req_ready[d]), 32'd1);
      check_eq(tg(d, "idle_fill_addr"), 32'(fill_address[d]), 32'(last_fa[d]));
      check_eq(tg(d, "idle_fill_data"), 32'(fill_data[d]), 32'(last_fd[d]));
    end
  endtask

  task automatic reset_in_wb(input int d, input logic [7:0] a, input logic [7:0] wa,
                             input logic [7:0] wd);
    int w;
    check_eq(tg(d, "rst_pre_ready"), 32'(req_ready[d]), 32'd1);
    req_valid[d]   = 1'b1;
    req_address[d] = a;
    wb_valid[d]    = 1'b1;
    wb_address[d]  = wa;
    wb_data[d]     = wd;
    @(posedge clock);
    @(negedge clock);
    req_valid[d] = 1'b0;
    check_eq(tg(d, "rst_in_wb_busy"), 32'(busy[d]), 32'd1);
    resetn[d] = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_eq(tg(d, "rst_ready"), 32'(req_ready[d]), 32'd1);
    check_eq(tg(d, "rst_busy"), 32'(busy[d]), 32'd0);
    check_eq(tg(d, "rst_state"), 32'(dbg_state[d]), 32'(IDLE));
    check_eq(tg(d, "rst_fill_valid"), 32'(fill_valid[d]), 32'd0);
    check_eq(tg(d, "rst_fill_addr"), 32'(fill_address[d]), 32'd0);
    check_eq(tg(d, "rst_fill_data"), 32'(fill_data[d]), 32'd0);
    resetn[d]  = 1'b1;
    last_fa[d] = 8'h00;
    last_fd[d] = 8'h00;
    idle_cycles(d, 2 * lat[d] + 3);
    // The aborted write-back must leave the victim word untouched.
    do_txn(d, wa, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, w);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int         w;
    logic [7:0] a, wa, wd;
    logic       wv;
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0; req_valid[d] = 1'b0; req_address[d] = 8'h00;
      wb_valid[d] = 1'b0; wb_address[d] = 8'h00; wb_data[d] = 8'h00;
      last_fa[d] = 8'h00; last_fd[d] = 8'h00;
      for (int i = 0; i < 256; i++) ref_mem[d][i] = 8'(i);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check_eq(tg(d, "reset_ready"), 32'(req_ready[d]), 32'd1);
      check_eq(tg(d, "reset_busy"), 32'(busy[d]), 32'd0);
      check_eq(tg(d, "reset_fill_valid"), 32'(fill_valid[d]), 32'd0);
      check_eq(tg(d, "reset_fill_addr"), 32'(fill_address[d]), 32'd0);
      check_eq(tg(d, "reset_fill_data"), 32'(fill_data[d]), 32'd0);
      resetn[d] = 1'b1;
    end

    for (int d = 0; d < 2; d++) begin
      do_txn(d, 8'h10, 1'b0, 8'h99, 8'h77, 1'b0, 8'h00, w);   // clean miss
      do_txn(d, 8'h20, 1'b1, 8'h04, 8'hAA, 1'b0, 8'h00, w);   // dirty miss
      do_txn(d, 8'h04, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, w);   // written-back word
      idle_cycles(d, 2);
      do_txn(d, 8'h33, 1'b1, 8'h33, 8'h5C, 1'b0, 8'h00, w);   // same address
      do_txn(d, 8'h50, 1'b0, 8'h00, 8'h00, 1'b1, 8'h40, w);   // 0x40 held while busy
      do_txn(d, 8'h40, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, w);
      check_eq(tg(d, "held_accept_wait"), 32'(w), 32'd0);
      if (d == 0) reset_in_wb(d, 8'h66, 8'h21, 8'hC3);
      for (int k = 0; k < 40; k++) begin
        a  = 8'($urandom_range(0, 255));
        wv = 1'($urandom_range(0, 1));
        wa = ($urandom_range(0, 3) == 0) ? a : 8'($urandom_range(0, 255));
        wd = 8'($urandom_range(0, 255));
        do_txn(d, a, wv, wa, wd, 1'b0, 8'h00, w);
        idle_cycles(d, $urandom_range(0, 3));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
